// File: rtl/material_pkg.sv
// Shared encodings for the material sequencer: temperature classes, FSM states,
// default thresholds/route and the sample classifier.
package material_pkg;

  typedef enum logic [1:0] {
    CLS_AMB  = 2'd0,
    CLS_HOT  = 2'd1,
    CLS_COLD = 2'd2
  } classT;

  // 4-bit encoding leaves spare codes so corrupted state is recoverable.
  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    READ        = 4'd1,
    ACCEPT      = 4'd2,
    REJECT      = 4'd3,
    LEAVE_DROP  = 4'd4,
    FIND_PICKUP = 4'd5,
    PICKUP      = 4'd6,
    HOLD        = 4'd7
  } stateT;

  localparam int DEF_COLD_TH = 1200;
  localparam int DEF_HOT_TH  = 1900;

  // Station 0 in the LSBs: AMB, HOT, COLD, AMB.
  localparam logic [7:0] DEF_ROUTE = {CLS_AMB, CLS_COLD, CLS_HOT, CLS_AMB};

  function automatic classT classifyTemp(input logic [31:0] temp,
                                         input logic [31:0] coldTh,
                                         input logic [31:0] hotTh);
    if (temp <= coldTh) return CLS_COLD;
    if (temp >= hotTh) return CLS_HOT;
    return CLS_AMB;
  endfunction

endpackage

// File: rtl/trigger_debounce.sv
// Two-flop synchroniser for the raw pillar detect followed by a tick-rate
// debouncer: clean follows raw only after DEBOUNCE consecutive differing ticks.
module trigger_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic raw,
  output logic clean
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      if (tick) begin
        // Any tick that agrees with the accepted level restarts the count.
        if (sync1 == clean) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
          clean <= sync1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/material_sequencer.sv
// Pillar-sorting sequencer: reads a temperature class at each station, accepts
// or rejects it against the route, then drives the magnet/servo pickup cycle.
module material_sequencer
  import material_pkg::*;
#(
  parameter int                        NUM_STATIONS = 4,
  parameter int                        TEMP_W       = 12,
  parameter int                        TICK_DIV     = 50,
  parameter int                        DEBOUNCE     = 3,
  parameter int                        DWELL        = 5,
  parameter int                        READ_TO      = 20,
  parameter logic [TEMP_W-1:0]         COLD_TH      = TEMP_W'(DEF_COLD_TH),
  parameter logic [TEMP_W-1:0]         HOT_TH       = TEMP_W'(DEF_HOT_TH),
  parameter logic [2*NUM_STATIONS-1:0] ROUTE        = (2*NUM_STATIONS)'(DEF_ROUTE)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            trigger,
  input  logic [TEMP_W-1:0]               digitalTemp,
  input  logic                            ready,
  output logic [$clog2(NUM_STATIONS)-1:0] stationIdx,
  output logic                            correctStation,
  output logic                            wrongStation,
  output logic                            lapDone,
  output logic                            controlEM,
  output logic                            controlServo,
  output stateT                           debugState
);

  localparam int IDX_W = $clog2(NUM_STATIONS);
  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int RCW   = $clog2(READ_TO + 1);
  localparam int DCW   = $clog2(DWELL + 1);

  logic [DIV_W-1:0] divCnt;
  logic             tick;
  logic             trigDb;
  logic [RCW-1:0]   readCnt;
  logic [DCW-1:0]   dwellCnt;
  stateT            state;
  classT            sampleClass;
  classT            expClass;

  assign tick = (divCnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST || tick) divCnt <= '0;
    else             divCnt <= divCnt + 1'b1;
  end

  trigger_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) uDebounce (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick),
    .raw  (trigger),
    .clean(trigDb)
  );

  assign sampleClass = classifyTemp(32'(digitalTemp), 32'(COLD_TH), 32'(HOT_TH));
  assign expClass    = classT'(ROUTE[2*int'(stationIdx) +: 2]);
  assign debugState  = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      stationIdx     <= '0;
      correctStation <= 1'b0;
      wrongStation   <= 1'b0;
      lapDone        <= 1'b0;
      controlEM      <= 1'b0;
      controlServo   <= 1'b0;
      readCnt        <= '0;
      dwellCnt       <= '0;
    end else begin
      // Status pulses last exactly one CLK even though states last a tick.
      wrongStation <= 1'b0;
      lapDone      <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            controlServo   <= 1'b0;
            correctStation <= 1'b0;
            if (trigDb) begin
              state   <= READ;
              readCnt <= '0;
            end
          end
          READ: begin
            if (ready) begin
              state <= (sampleClass == expClass) ? ACCEPT : REJECT;
            end else if (readCnt == RCW'(READ_TO - 1)) begin
              state <= REJECT;
            end else begin
              readCnt <= readCnt + 1'b1;
            end
          end
          ACCEPT: begin
            controlEM      <= 1'b0;
            correctStation <= 1'b1;
            if (stationIdx == IDX_W'(NUM_STATIONS - 1)) begin
              stationIdx <= '0;
              lapDone    <= 1'b1;
            end else begin
              stationIdx <= stationIdx + 1'b1;
            end
            state <= LEAVE_DROP;
          end
          REJECT: begin
            wrongStation <= 1'b1;
            state        <= LEAVE_DROP;
          end
          LEAVE_DROP: begin
            if (!trigDb) state <= FIND_PICKUP;
          end
          FIND_PICKUP: begin
            if (trigDb) begin
              state        <= PICKUP;
              controlEM    <= 1'b1;
              controlServo <= correctStation;
              dwellCnt     <= '0;
            end
          end
          PICKUP: begin
            // Pillar leaving early aborts the dwell but keeps the load held.
            if (!trigDb) begin
              state          <= IDLE;
              controlServo   <= 1'b0;
              correctStation <= 1'b0;
            end else if (dwellCnt == DCW'(DWELL - 1)) begin
              state        <= HOLD;
              controlServo <= 1'b0;
            end else begin
              dwellCnt <= dwellCnt + 1'b1;
            end
          end
          HOLD: begin
            if (!trigDb) begin
              state          <= IDLE;
              controlServo   <= 1'b0;
              correctStation <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_material_sequencer.sv
// Directed bench for material_sequencer at default parameters: one full station
// visit per vector, with hand-derived class, index, pulse and actuator values.
module tb_material_sequencer;
  import material_pkg::*;

  localparam int TICK_DIV = 50;
  localparam int READ_TO  = 20;
  localparam int DWELL    = 5;

  logic        CLK         = 1'b0;
  logic        RST         = 1'b1;
  logic        trigger     = 1'b0;
  logic        ready       = 1'b0;
  logic [11:0] digitalTemp = 12'd0;
  logic [1:0]  stationIdx;
  logic        correctStation;
  logic        wrongStation;
  logic        lapDone;
  logic        controlEM;
  logic        controlServo;
  stateT       debugState;

  int nCompared   = 0;
  int nMismatched = 0;
  bit emExp       = 1'b0;

  always #5 CLK = ~CLK;

  material_sequencer dut (
    .CLK           (CLK),
    .RST           (RST),
    .trigger       (trigger),
    .digitalTemp   (digitalTemp),
    .ready         (ready),
    .stationIdx    (stationIdx),
    .correctStation(correctStation),
    .wrongStation  (wrongStation),
    .lapDone       (lapDone),
    .controlEM     (controlEM),
    .controlServo  (controlServo),
    .debugState    (debugState)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns 1ns after the n-th tick edge, so FSM updates are visible.
  task automatic waitTicks(input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      @(negedge CLK);
      while (!dut.tick && guard < 2*TICK_DIV) begin
        @(negedge CLK);
        guard++;
      end
      if (guard >= 2*TICK_DIV) checkEq("tick_timeout", 32'(dut.tick), 32'd1);
      @(posedge CLK);
      #1;
    end
  endtask

  // mode 0: full dwell then HOLD; 1: pillar leaves mid-PICKUP; 2: RST mid-PICKUP.
  task automatic visit(input logic [11:0] temp, input bit rdy, input bit expAcc,
                       input int expIdx, input bit expLap, input int mode);
    digitalTemp = temp;
    ready       = 1'b0;
    trigger     = 1'b1;
    waitTicks(3);
    checkEq("pre_read_idle", 32'(debugState), 32'(IDLE));
    waitTicks(1);
    checkEq("read_state", 32'(debugState), 32'(READ));
    if (rdy) begin
      ready = 1'b1;
      waitTicks(1);
      ready = 1'b0;
    end else begin
      waitTicks(READ_TO - 1);
      checkEq("timeout_still_read", 32'(debugState), 32'(READ));
      waitTicks(1);
    end
    checkEq("decide_state", 32'(debugState), 32'(expAcc ? ACCEPT : REJECT));
    waitTicks(1);
    checkEq("wrong_pulse", 32'(wrongStation), 32'(!expAcc));
    checkEq("lap_pulse", 32'(lapDone), 32'(expLap));
    checkEq("correct_station", 32'(correctStation), 32'(expAcc));
    checkEq("station_idx", 32'(stationIdx), 32'(expIdx));
    if (expAcc) emExp = 1'b0;
    checkEq("em_after_decide", 32'(controlEM), 32'(emExp));
    checkEq("leave_drop_state", 32'(debugState), 32'(LEAVE_DROP));
    @(posedge CLK);
    #1;
    checkEq("wrong_clear", 32'(wrongStation), 32'd0);
    checkEq("lap_clear", 32'(lapDone), 32'd0);

    trigger = 1'b0;
    waitTicks(4);
    checkEq("find_pickup_state", 32'(debugState), 32'(FIND_PICKUP));
    trigger = 1'b1;
    waitTicks(4);
    checkEq("pickup_state", 32'(debugState), 32'(PICKUP));
    checkEq("em_pickup", 32'(controlEM), 32'd1);
    checkEq("servo_pickup", 32'(controlServo), 32'(expAcc));
    emExp = 1'b1;

    if (mode == 0) begin
      waitTicks(DWELL - 1);
      checkEq("dwell_still_pickup", 32'(debugState), 32'(PICKUP));
      waitTicks(1);
      checkEq("hold_state", 32'(debugState), 32'(HOLD));
      checkEq("servo_hold", 32'(controlServo), 32'd0);
      checkEq("em_hold", 32'(controlEM), 32'd1);
      trigger = 1'b0;
      waitTicks(4);
      checkEq("hold_to_idle", 32'(debugState), 32'(IDLE));
      checkEq("correct_idle", 32'(correctStation), 32'd0);
      checkEq("em_idle", 32'(controlEM), 32'd1);
    end else if (mode == 1) begin
      trigger = 1'b0;
      waitTicks(4);
      checkEq("early_idle", 32'(debugState), 32'(IDLE));
      checkEq("early_servo_up", 32'(controlServo), 32'd0);
      checkEq("early_em_kept", 32'(controlEM), 32'd1);
    end else begin
      waitTicks(2);
      checkEq("rst_pre_servo", 32'(controlServo), 32'(expAcc));
      checkEq("rst_pre_em", 32'(controlEM), 32'd1);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      checkEq("rst_state", 32'(debugState), 32'(IDLE));
      checkEq("rst_idx", 32'(stationIdx), 32'd0);
      checkEq("rst_em", 32'(controlEM), 32'd0);
      checkEq("rst_servo", 32'(controlServo), 32'd0);
      checkEq("rst_correct", 32'(correctStation), 32'd0);
      checkEq("rst_wrong", 32'(wrongStation), 32'd0);
      checkEq("rst_lap", 32'(lapDone), 32'd0);
      @(negedge CLK);
      RST     = 1'b0;
      trigger = 1'b0;
      emExp   = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    checkEq("reset_state", 32'(debugState), 32'(IDLE));
    checkEq("reset_idx", 32'(stationIdx), 32'd0);
    checkEq("reset_em", 32'(controlEM), 32'd0);
    checkEq("reset_servo", 32'(controlServo), 32'd0);
    checkEq("reset_correct", 32'(correctStation), 32'd0);
    checkEq("reset_wrong", 32'(wrongStation), 32'd0);
    checkEq("reset_lap", 32'(lapDone), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Two-tick glitch must be filtered out.
    trigger = 1'b1;
    waitTicks(2);
    trigger = 1'b0;
    waitTicks(4);
    checkEq("glitch_idle", 32'(debugState), 32'(IDLE));

    visit(12'd1500, 1'b1, 1'b1, 1, 1'b0, 0);  // st0 AMB
    visit(12'd1899, 1'b1, 1'b0, 1, 1'b0, 0);  // st1 wants HOT, 1899 is AMB
    visit(12'd1900, 1'b1, 1'b1, 2, 1'b0, 1);  // st1 HOT at threshold
    visit(12'd1200, 1'b1, 1'b1, 3, 1'b0, 0);  // st2 COLD at threshold
    visit(12'd1201, 1'b1, 1'b1, 0, 1'b1, 0);  // st3 AMB, lap wraps
    visit(12'd1500, 1'b0, 1'b0, 0, 1'b0, 0);  // no ready -> timeout reject
    visit(12'd1500, 1'b1, 1'b1, 1, 1'b0, 2);  // reset during pickup

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d",
             nCompared, nMismatched);
    $fatal(1, "time limit");
  end

endmodule
